// File: rtl/adam_pause_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adam_pause_pkg
// Purpose  : Shared types and helpers for the ADAM_PAUSE responder blocks.
//            - adam_pause_state_t : responder FSM state encoding (2 bits)
//            - cnt_width()        : width of an outstanding-transaction counter
// Revision : 1.0 - initial release
// ============================================================================
package adam_pause_pkg;

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RUNNING  = 2'd1,
    DRAINING = 2'd2,
    SETTLE   = 2'd3
  } adam_pause_state_t;

  // Bits needed to hold 0..max_count inclusive (never less than 1).
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/adam_pause_outstanding_cnt.sv
`default_nettype none
// ============================================================================
// Module   : adam_pause_outstanding_cnt
// Purpose  : Saturating in-flight transaction counter for pausable blocks.
// Ports    : clk          in  clock, posedge
//            rst          in  synchronous reset, active-low
//            inc          in  one transaction started this cycle
//            dec          in  one transaction completed this cycle
//            count        out registered in-flight count
//            is_zero_next out count will be zero after the coming edge
//            range_err    out this cycle's update would over/underflow
// Revision : 1.0 - initial release
// ============================================================================
module adam_pause_outstanding_cnt
  import adam_pause_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inc,
  input  logic                              dec,
  output logic [cnt_width(MAX_COUNT)-1:0]   count,
  output logic                              is_zero_next,
  output logic                              range_err
);

  localparam int unsigned    CW      = cnt_width(MAX_COUNT);
  localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_COUNT);
  localparam logic [CW-1:0]  ONE     = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // inc and dec together cancel; an illegal step holds the count and flags.
  always_comb begin
    count_d   = count_q;
    range_err = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q == MAX_CNT) range_err = 1'b1;
        else                    count_d   = count_q + ONE;
      end
      2'b01: begin
        if (count_q == '0) range_err = 1'b1;
        else               count_d   = count_q - ONE;
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count        = count_q;
  assign is_zero_next = (count_d == '0);

endmodule
`default_nettype wire

// File: rtl/adam_pause_slave.sv
`default_nettype none
// ============================================================================
// Module   : adam_pause_slave
// Purpose  : Responder end of the ADAM_PAUSE req/ack handshake. Blocks new
//            transaction starts on request, drains in-flight work, waits a
//            settle window, then acknowledges. Comes out of reset paused.
// Ports    : clk         in  clock, posedge
//            rst         in  synchronous reset, active-low
//            pause_req   in  1 = pause requested
//            pause_ack   out 1 = paused (registered)
//            start_req   in  local logic wants to start a transaction
//            start_gnt   out start permitted (combinational)
//            done        in  one transaction completed this cycle
//            outstanding out in-flight count (registered)
//            proto_err   out sticky protocol error, cleared by reset only
// Revision : 1.0 - initial release
// ============================================================================
module adam_pause_slave
  import adam_pause_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DRAIN_CYCLES    = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pause_req,
  output logic                                   pause_ack,
  input  logic                                   start_req,
  output logic                                   start_gnt,
  input  logic                                   done,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0]  outstanding,
  output logic                                   proto_err
);

  localparam int unsigned   CW          = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_OUTSTANDING);
  localparam int unsigned   SW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned   SETTLE_INIT = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_INIT);

  adam_pause_state_t state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              pause_ack_q, pause_ack_d;
  logic              proto_err_q, proto_err_d;

  logic              accept;
  logic              zero_next;
  logic              cnt_err;
  logic              req_violation;

  // Grants are held off during reset so nothing leaks out while the
  // registered state is still being forced.
  assign start_gnt = rst && (state_q == RUNNING) && !pause_req &&
                     (outstanding < MAX_CNT);
  assign accept    = start_req && start_gnt;

  adam_pause_outstanding_cnt #(
    .MAX_COUNT    (MAX_OUTSTANDING)
  ) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .inc          (accept),
    .dec          (done),
    .count        (outstanding),
    .is_zero_next (zero_next),
    .range_err    (cnt_err)
  );

  always_comb begin
    state_d       = state_q;
    settle_d      = settle_q;
    req_violation = 1'b0;
    case (state_q)
      PAUSED: begin
        if (!pause_req) state_d = RUNNING;
      end
      RUNNING, DRAINING: begin
        // Dropping the request mid-drain breaks the four-phase rule; the
        // pause is still completed so the handshake resynchronises.
        if (state_q == DRAINING && !pause_req) req_violation = 1'b1;
        if (pause_req || state_q == DRAINING) begin
          if (zero_next) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = PAUSED;
            end else begin
              state_d  = SETTLE;
              settle_d = SETTLE_LOAD;
            end
          end else begin
            state_d = DRAINING;
          end
        end
      end
      SETTLE: begin
        if (!pause_req) req_violation = 1'b1;
        // Completions here are counted but do not restart the window.
        if (settle_q == '0) state_d  = PAUSED;
        else                settle_d = settle_q - SW'(1);
      end
      default: state_d = PAUSED;
    endcase
    pause_ack_d = (state_d == PAUSED);
    proto_err_d = proto_err_q || cnt_err || req_violation;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= PAUSED;
      settle_q    <= '0;
      pause_ack_q <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pause_ack_q <= pause_ack_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign pause_ack = pause_ack_q;
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_adam_pause_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_adam_pause_slave
// Purpose  : Directed, table-driven bench for adam_pause_slave
//            (MAX_OUTSTANDING=8, DRAIN_CYCLES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adam_pause_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       pause_req;
  logic       start_req;
  logic       done;
  logic       pause_ack;
  logic       start_gnt;
  logic [3:0] outstanding;
  logic       proto_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       r, p, s, d;
    logic       ack, gnt;
    logic [3:0] out;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  adam_pause_slave #(
    .MAX_OUTSTANDING (8),
    .DRAIN_CYCLES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pause_req   (pause_req),
    .pause_ack   (pause_ack),
    .start_req   (start_req),
    .start_gnt   (start_gnt),
    .done        (done),
    .outstanding (outstanding),
    .proto_err   (proto_err)
  );

  task automatic add(input logic r, input logic p, input logic s, input logic d,
                     input logic ack, input logic gnt, input int out, input logic err);
    vec_t v;
    v.r = r; v.p = p; v.s = s; v.d = d;
    v.ack = ack; v.gnt = gnt; v.out = 4'(out); v.err = err;
    vecs.push_back(v);
  endtask

  // Drive inputs (just after a posedge), check at the negedge, then advance
  // past the next posedge. Registered outputs reflect the previous edge;
  // start_gnt reflects the inputs being driven now.
  task automatic step(input string name,
                      input logic r, input logic p, input logic s, input logic d,
                      input logic ack, input logic gnt, input logic [3:0] out,
                      input logic err);
    rst = r; pause_req = p; start_req = s; done = d;
    @(negedge clk);
    n_vec++;
    if (pause_ack !== ack || start_gnt !== gnt || outstanding !== out ||
        proto_err !== err) begin
      n_bad++;
      $display("FAIL %s: got ack=%b gnt=%b out=%0d err=%b, want ack=%b gnt=%b out=%0d err=%b",
               name, pause_ack, start_gnt, outstanding, proto_err, ack, gnt, out, err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pause_req = 1'b1; start_req = 1'b0; done = 1'b0;

    //    r  p  s  d   ack gnt out err
    // Reset release
    add(0, 1, 1, 0,   1,  0,  0,  0);   // in reset: grant gated
    add(1, 1, 1, 0,   1,  0,  0,  0);   // paused, req held
    add(1, 0, 1, 0,   1,  0,  0,  0);   // release request
    // Three starts, then pause with traffic
    add(1, 0, 1, 0,   0,  1,  0,  0);
    add(1, 0, 1, 0,   0,  1,  1,  0);
    add(1, 0, 1, 0,   0,  1,  2,  0);
    add(1, 1, 1, 0,   0,  0,  3,  0);   // req up: grant drops at once
    add(1, 1, 1, 1,   0,  0,  3,  0);   // done 1
    add(1, 1, 0, 0,   0,  0,  2,  0);
    add(1, 1, 0, 1,   0,  0,  2,  0);   // done 2
    add(1, 1, 0, 1,   0,  0,  1,  0);   // done 3: count hits 0 at this edge
    add(1, 1, 0, 0,   0,  0,  0,  0);   // settle 1 of 2
    add(1, 1, 0, 0,   0,  0,  0,  0);   // settle 2 of 2
    add(1, 1, 1, 0,   1,  0,  0,  0);   // ack up two edges after zero
    // Saturation: 12 cycles of start_req
    add(1, 0, 1, 0,   1,  0,  0,  0);
    for (int i = 0; i < 8; i++) add(1, 0, 1, 0, 0, 1, i, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 0, 8, 0);
    add(1, 0, 1, 1,   0,  0,  8,  0);   // one done
    add(1, 0, 1, 0,   0,  1,  7,  0);   // exactly one more grant
    add(1, 0, 1, 0,   0,  0,  8,  0);
    // Down to 4, then start+done together
    add(1, 0, 0, 1,   0,  0,  8,  0);
    add(1, 0, 0, 1,   0,  1,  7,  0);
    add(1, 0, 0, 1,   0,  1,  6,  0);
    add(1, 0, 0, 1,   0,  1,  5,  0);
    add(1, 0, 1, 1,   0,  1,  4,  0);   // simultaneous
    add(1, 0, 0, 0,   0,  1,  4,  0);   // still 4
    for (int i = 4; i > 0; i--) add(1, 0, 0, 1, 0, 1, i, 0);
    add(1, 0, 0, 1,   0,  1,  0,  0);   // done with count 0
    add(1, 0, 0, 0,   0,  1,  0,  1);   // no wrap, error set
    add(1, 0, 0, 0,   0,  1,  0,  1);   // sticky

    repeat (3) @(posedge clk);
    #1;
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].r, vecs[i].p, vecs[i].s, vecs[i].d,
           vecs[i].ack, vecs[i].gnt, vecs[i].out, vecs[i].err);

    // Reset in the middle of a drain with five in flight
    for (int i = 0; i < 5; i++)
      step($sformatf("a_start%0d", i), 1, 0, 1, 0, 0, 1, 4'(i), 1);
    step("a_req",   1, 1, 0, 0, 0, 0, 4'd5, 1);
    step("a_drain", 1, 1, 0, 0, 0, 0, 4'd5, 1);
    step("a_rst",   0, 1, 0, 0, 0, 0, 4'd5, 1);
    step("a_post",  1, 1, 0, 0, 1, 0, 4'd0, 0);

    // Request dropped during the settle window
    step("b_rel",    1, 0, 0, 0, 1, 0, 4'd0, 0);
    step("b_req",    1, 1, 0, 0, 0, 0, 4'd0, 0);
    step("b_drop",   1, 0, 0, 0, 0, 0, 4'd0, 0);
    step("b_err",    1, 0, 0, 0, 0, 0, 4'd0, 1);
    step("b_paused", 1, 0, 0, 0, 1, 0, 4'd0, 1);
    step("b_resume", 1, 0, 1, 0, 0, 1, 4'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
